adc_pattern_tx: RTL

- Transmit-side counterpart of the AD9284 LVDS DDR capture path.
- Generates AD9284-style interleaved sample streams: channel A byte for the rising DCO edge, channel B byte for the falling edge.
- Outputs feed per-lane ODDR + OBUFDS in the top level, so loopback and interposer tests can run without a live ADC.
- Includes a training preamble, selectable test patterns, a glitch-free mode-change handshake and a sample counter.

---
 rtl/adc_pattern_tx_if.sv | 38 +++
 rtl/adc_pattern_tx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/adc_pattern_tx_if.sv
// -----------------------------------------------------------------------------
// adc_pattern_tx_if
// Bundles the control and sample-stream signals of adc_pattern_tx.
//   enable       : level, high = transmit
//   mode         : pattern select, captured on mode_load
//   fixed_word   : byte for fixed mode, captured on mode_load
//   mode_load    : one-cycle pattern change request
//   mode_busy    : a loaded mode is waiting to be applied
//   data_p/data_n: rising/falling DCO edge bytes (channel A / channel B)
//   dco_en       : gates the forwarded DCO
//   valid        : high in TRAIN and RUN
//   train_active : high in TRAIN
//   sample_count : RUN cycles since last entry to RUN (saturating)
// master drives the controls; slave is the pattern generator.
// -----------------------------------------------------------------------------
interface adc_pattern_tx_if;
   logic        enable;
   logic [2:0]  mode;
   logic [7:0]  fixed_word;
   logic        mode_load;
   logic        mode_busy;
   logic [7:0]  data_p;
   logic [7:0]  data_n;
   logic        dco_en;
   logic        valid;
   logic        train_active;
   logic [31:0] sample_count;

   modport master (
      output enable, mode, fixed_word, mode_load,
      input  mode_busy, data_p, data_n, dco_en, valid, train_active, sample_count
   );

   modport slave (
      input  enable, mode, fixed_word, mode_load,
      output mode_busy, data_p, data_n, dco_en, valid, train_active, sample_count
   );
endinterface

// File: rtl/adc_pattern_tx.sv
// -----------------------------------------------------------------------------
// adc_pattern_tx
// Generates AD9284-style interleaved DDR byte streams for per-lane ODDR:
// a training word pair after enable, then a selectable test pattern.
//   clock_in : sample clock
//   reset    : synchronous, active-high, highest priority
//   bus      : adc_pattern_tx_if.slave (controls in, registered outputs out)
// -----------------------------------------------------------------------------
module adc_pattern_tx #(
   parameter int         TRAIN_WORDS = 64,
   parameter logic [8:0] PN_SEED     = 9'h1FF
) (
   input logic             clock_in,
   input logic             reset,
   adc_pattern_tx_if.slave bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_TRAIN, ST_RUN} state_e;
   typedef enum logic [2:0] {PAT_RAMP, PAT_CHECK, PAT_TOGGLE, PAT_PN9, PAT_FIXED} pattern_e;

   localparam int          CW         = (TRAIN_WORDS > 1) ? $clog2(TRAIN_WORDS) : 1;
   localparam logic [CW-1:0] TRAIN_LAST = CW'(TRAIN_WORDS - 1);

   state_e        r_state, w_state_nxt;
   logic [CW-1:0] r_train_cnt, w_train_cnt_nxt;
   logic [2:0]    r_act_mode, r_pend_mode;
   logic [7:0]    r_act_fixed, r_pend_fixed;
   logic          r_busy;
   logic [7:0]    r_ramp;
   logic          r_tog;
   logic [8:0]    r_lfsr;
   logic [7:0]    r_data_p, r_data_n;
   logic          r_dco_en, r_valid, r_train;
   logic [31:0]   r_count;

   logic          w_apply, w_restart;
   logic [2:0]    w_mode_eff;
   logic [7:0]    w_fixed_eff;
   logic [7:0]    w_ramp_base;
   logic          w_tog_base;
   logic [8:0]    w_lfsr_base, w_lfsr_adv;
   logic [15:0]   w_pn_bits;
   logic [7:0]    w_p_nxt, w_n_nxt;
   logic          w_dco_nxt, w_valid_nxt, w_train_nxt;
   logic [31:0]   w_count_nxt;

   // Sixteen PN9 steps; returns {bits (first bit in MSB), state after step 16}.
   function automatic logic [24:0] pn_step16(input logic [8:0] seed);
      logic [8:0]  s;
      logic [15:0] bits;
      logic        b;
      s    = seed;
      bits = '0;
      for (int i = 0; i < 16; i++) begin
         b          = s[8] ^ s[4];
         bits[15-i] = b;
         s          = {s[7:0], b};
      end
      return {bits, s};
   endfunction

   // Next-state logic
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt     = r_state;
      w_train_cnt_nxt = '0;
      case (r_state)
         ST_IDLE:  if (bus.enable) w_state_nxt = ST_TRAIN;
         ST_TRAIN: begin
            if (!bus.enable)                 w_state_nxt = ST_IDLE;
            else if (r_train_cnt == TRAIN_LAST) w_state_nxt = ST_RUN;
            else                             w_train_cnt_nxt = r_train_cnt + 1'b1;
         end
         ST_RUN:   if (!bus.enable) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Output datapath, computed for the cycle after the coming edge
   always_comb begin
      // A load coinciding with a pending mode overwrites it and defers the
      // application, so only the last requested pattern ever reaches the pins.
      w_apply     = (w_state_nxt == ST_RUN) && r_busy && !bus.mode_load;
      w_restart   = (r_state != ST_RUN) || w_apply;
      w_mode_eff  = w_apply ? r_pend_mode  : r_act_mode;
      w_fixed_eff = w_apply ? r_pend_fixed : r_act_fixed;
      w_ramp_base = w_restart ? 8'h00   : r_ramp;
      w_tog_base  = w_restart ? 1'b0    : r_tog;
      w_lfsr_base = w_restart ? PN_SEED : r_lfsr;
      {w_pn_bits, w_lfsr_adv} = pn_step16(w_lfsr_base);

      w_p_nxt     = 8'h00;
      w_n_nxt     = 8'h00;
      w_dco_nxt   = 1'b0;
      w_valid_nxt = 1'b0;
      w_train_nxt = 1'b0;
      w_count_nxt = '0;
      case (w_state_nxt)
         ST_TRAIN: begin
            w_p_nxt     = 8'hA5;
            w_n_nxt     = 8'h5A;
            w_dco_nxt   = 1'b1;
            w_valid_nxt = 1'b1;
            w_train_nxt = 1'b1;
         end
         ST_RUN: begin
            w_dco_nxt   = 1'b1;
            w_valid_nxt = 1'b1;
            if (r_state != ST_RUN)  w_count_nxt = 32'd1;
            else if (&r_count)      w_count_nxt = r_count;
            else                    w_count_nxt = r_count + 32'd1;
            case (w_mode_eff)
               PAT_RAMP:   begin w_p_nxt = w_ramp_base; w_n_nxt = w_ramp_base + 8'd1; end
               PAT_CHECK:  begin w_p_nxt = 8'h55; w_n_nxt = 8'hAA; end
               PAT_TOGGLE: begin w_p_nxt = {8{w_tog_base}}; w_n_nxt = {8{~w_tog_base}}; end
               PAT_PN9:    begin w_p_nxt = w_pn_bits[15:8]; w_n_nxt = w_pn_bits[7:0]; end
               PAT_FIXED:  begin w_p_nxt = w_fixed_eff; w_n_nxt = w_fixed_eff; end
               default:    begin w_p_nxt = 8'h00; w_n_nxt = 8'h00; end
            endcase
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from pre-edge values.
   // NOTE: every register, including generator and mode state, is reset so a
   // mid-operation reset leaves no residue of the aborted pattern.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_train_cnt  <= '0;
         r_act_mode   <= PAT_RAMP;
         r_act_fixed  <= 8'h00;
         r_pend_mode  <= 3'd0;
         r_pend_fixed <= 8'h00;
         r_busy       <= 1'b0;
         r_ramp       <= 8'h00;
         r_tog        <= 1'b0;
         r_lfsr       <= PN_SEED;
         r_data_p     <= 8'h00;
         r_data_n     <= 8'h00;
         r_dco_en     <= 1'b0;
         r_valid      <= 1'b0;
         r_train      <= 1'b0;
         r_count      <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_train_cnt <= w_train_cnt_nxt;
         if (bus.mode_load) begin
            r_pend_mode  <= bus.mode;
            r_pend_fixed <= bus.fixed_word;
            r_busy       <= 1'b1;
         end else if (w_apply) begin
            r_busy <= 1'b0;
         end
         if (w_apply) begin
            r_act_mode  <= r_pend_mode;
            r_act_fixed <= r_pend_fixed;
         end
         if (w_state_nxt == ST_RUN) begin
            r_ramp <= w_ramp_base + 8'd2;
            r_tog  <= ~w_tog_base;
            r_lfsr <= w_lfsr_adv;
         end
         r_data_p <= w_p_nxt;
         r_data_n <= w_n_nxt;
         r_dco_en <= w_dco_nxt;
         r_valid  <= w_valid_nxt;
         r_train  <= w_train_nxt;
         r_count  <= w_count_nxt;
      end
   end

   assign bus.data_p       = r_data_p;
   assign bus.data_n       = r_data_n;
   assign bus.dco_en       = r_dco_en;
   assign bus.valid        = r_valid;
   assign bus.train_active = r_train;
   assign bus.mode_busy    = r_busy;
   assign bus.sample_count = r_count;

endmodule
